// File: rtl/frame_fifo_reader_pkg.sv
// frame_fifo_reader_pkg: shared types for the frame FIFO read stage.
// Holds the read-stage state encoding and the skid entry layout {last, data},
// which the egress scheduler reuses.
package frame_fifo_reader_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_GAP} state_t;
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } skid_entry_t;
endpackage

// File: rtl/frame_fifo_reader_skid_fifo2.sv
// skid_fifo2: 2-entry skid FIFO of {last, data} entries.
// Ports: clk, arst (async, active-high), push/din write side, pop/dout read
// side (dout is the head entry), occ = current occupancy (0..2).
module skid_fifo2
  import frame_fifo_reader_pkg::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic        push,
  input  skid_entry_t din,
  input  logic        pop,
  output skid_entry_t dout,
  output logic [1:0]  occ
);
  skid_entry_t [1:0] mem_q, mem_d;
  logic wp_q, wp_d, rp_q, rp_d;
  logic [1:0] occ_q, occ_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ pop;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_q <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      occ_q <= occ_d;
    end
  end
  assign dout = mem_q[rp_q];
  assign occ = occ_q;
  assert property (@(posedge clk) disable iff (arst) !(push && !pop && occ_q == 2'd2));
  assert property (@(posedge clk) disable iff (arst) !(pop && occ_q == 2'd0));
endmodule

// File: rtl/frame_fifo_reader.sv
// frame_fifo_reader: read-side stage turning FIFO bytes + EOD into framed tx beats.
// Ports: clk, arst (async, active-high); FIFO read port fifo_do/fifo_eod/
// fifo_empty/fifo_re (data one cycle after an accepted read); tx_data/
// tx_valid/tx_last/tx_ready stream; frame_cnt/trunc_cnt wrapping counters;
// busy = not IDLE.
module frame_fifo_reader
  import frame_fifo_reader_pkg::*;
#(
  parameter int MAX_LEN = 1514,
  parameter int IFG_CYC = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          arst,
  input  logic [7:0]    fifo_do,
  input  logic          fifo_eod,
  input  logic          fifo_empty,
  output logic          fifo_re,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  output logic          tx_last,
  input  logic          tx_ready,
  output logic [CW-1:0] frame_cnt,
  output logic [CW-1:0] trunc_cnt,
  output logic          busy
);
  localparam int BW = (MAX_LEN < 2048) ? 11 : $clog2(MAX_LEN + 1);
  localparam int GW = (IFG_CYC < 2) ? 1 : $clog2(IFG_CYC);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_LEN - 1);
  state_t state_q, state_d, gap_next;
  logic inflight_q, inflight_d;
  logic done_q, done_d;
  logic trunc_q, trunc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d, trunc_cnt_q, trunc_cnt_d;
  logic push, pop, at_max, eff_last, cut, room;
  skid_entry_t din, head;
  logic [1:0] occ;

  skid_fifo2 u_skid (
    .clk  (clk),
    .arst (arst),
    .push (push),
    .din  (din),
    .pop  (pop),
    .dout (head),
    .occ  (occ)
  );

  assign tx_valid = occ != 2'd0;
  assign tx_data = head.data;
  assign tx_last = head.last;
  assign pop = tx_valid & tx_ready;
  assign busy = state_q != ST_IDLE;
  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;

  always_comb begin
    push = inflight_q & (state_q == ST_STREAM);
    at_max = bcnt_q == LAST_IDX;
    eff_last = fifo_eod | at_max;
    cut = push & ~fifo_eod & at_max;
    din = '{last: eff_last, data: fifo_do};
    // A pop in this cycle frees a slot, which keeps reads flowing at one byte per cycle.
    room = ({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
    // The byte arriving now may close the frame; a read issued now would belong to the next frame.
    fifo_re = ~fifo_empty & room &
              (((state_q == ST_STREAM) & ~done_q & ~(push & eff_last)) |
               ((state_q == ST_DRAIN) & ~(inflight_q & fifo_eod)));
    gap_next = (IFG_CYC == 0) ? ST_IDLE : ST_GAP;
    state_d = state_q;
    inflight_d = fifo_re;
    done_d = done_q;
    trunc_d = trunc_q | cut;
    bcnt_d = push ? (eff_last ? '0 : bcnt_q + 1'b1) : bcnt_q;
    gap_d = gap_q;
    frame_cnt_d = (pop & tx_last) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    trunc_cnt_d = cut ? trunc_cnt_q + 1'b1 : trunc_cnt_q;
    if (push & eff_last) done_d = 1'b1;
    case (state_q)
      ST_IDLE: if (~fifo_empty) state_d = ST_STREAM;
      ST_STREAM:
        if (pop & tx_last) begin
          state_d = trunc_q ? ST_DRAIN : gap_next;
          done_d = 1'b0;
          trunc_d = 1'b0;
        end
      ST_DRAIN: if (inflight_q & fifo_eod) state_d = gap_next;
      default: begin
        state_d = (gap_q == GW'(IFG_CYC - 1)) ? ST_IDLE : ST_GAP;
        gap_d = (gap_q == GW'(IFG_CYC - 1)) ? '0 : gap_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
      trunc_q <= 1'b0;
      bcnt_q <= '0;
      gap_q <= '0;
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      inflight_q <= inflight_d;
      done_q <= done_d;
      trunc_q <= trunc_d;
      bcnt_q <= bcnt_d;
      gap_q <= gap_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end
endmodule
